// File: rtl/mt_sync_sender_pkg.sv
// Shared types for the clocked MOUSETRAP input-stage sender: FSM state encoding,
// default data width and a small width helper.
package mt_sync_sender_pkg;

   localparam int DEF_DATA_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_e;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mt_sync_sender_if.sv
// Upstream valid/ready stream plus the 2-phase bundled-data link to the pipeline.
// master = sender side, slave = environment (upstream producer and pipeline stage).
interface mt_sync_sender_if #(
   parameter int DATA_W = mt_sync_sender_pkg::DEF_DATA_W
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic [DATA_W-1:0] mt_data;
   logic              mt_req;
   logic              mt_ack;

   modport master (
      input  s_valid, s_data, mt_ack,
      output s_ready, mt_data, mt_req
   );

   modport slave (
      output s_valid, s_data, mt_ack,
      input  s_ready, mt_data, mt_req
   );
endinterface

// File: rtl/mt_sync_sender_fifo.sv
// Small first-word-fall-through FIFO: the head word is readable as soon as it is written,
// so the sender can load it on the very next edge.
module mt_sync_sender_fifo #(
   parameter  int DATA_W = 4,
   parameter  int DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output logic [CW-1:0]     count_o,
   output logic              full_o,
   output logic              empty_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              do_push;
   logic              do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/mt_sync_sender.sv
// Clocked front end for the MOUSETRAP input stage: buffers stream words, presents each
// on mt_data, waits a setup margin, toggles mt_req, then waits for the matching ack toggle.
module mt_sync_sender
   import mt_sync_sender_pkg::*;
#(
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int SETUP_CYC   = 2,
   parameter  int SYNC_STAGES = 2,
   localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   mt_sync_sender_if.master bus,
   output logic [CNT_W-1:0] fifo_count,
   output logic             busy,
   output logic             proto_err
);
   localparam int SC_W = cnt_width(SETUP_CYC);

   state_e                 state_q;
   logic [SC_W-1:0]        setup_cnt_q;
   logic [DATA_W-1:0]      mt_data_q;
   logic                   mt_req_q;
   logic                   proto_err_q;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_prev_q;
   logic                   ack_s;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [DATA_W-1:0]      fifo_head;

   mt_sync_sender_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (bus.s_valid & bus.s_ready),
      .pop_i   (pop),
      .wdata_i (bus.s_data),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ack_s       = ack_sync_q[SYNC_STAGES-1];
   assign pop         = (state_q == ST_IDLE) && !fifo_empty;
   assign bus.s_ready = ~fifo_full;
   assign bus.mt_data = mt_data_q;
   assign bus.mt_req  = mt_req_q;
   assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
   assign proto_err   = proto_err_q;

   // ack_prev_q remembers the previous synchronised ack so a change can be spotted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_sync_q <= '0;
         ack_prev_q <= 1'b0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.mt_ack};
         ack_prev_q <= ack_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         setup_cnt_q <= '0;
         mt_data_q   <= '0;
         mt_req_q    <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         // An ack edge is only legitimate while a request is outstanding.
         if ((ack_s != ack_prev_q) && (state_q inside {ST_IDLE, ST_SETUP}))
            proto_err_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  mt_data_q   <= fifo_head;
                  setup_cnt_q <= SC_W'(SETUP_CYC - 1);
                  state_q     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (setup_cnt_q == '0) begin
                  mt_req_q <= ~mt_req_q;
                  state_q  <= ST_WAIT_ACK;
               end else begin
                  setup_cnt_q <= setup_cnt_q - 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (ack_s == mt_req_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mt_sync_sender.sv
// Directed bench for mt_sync_sender: instance A (SETUP_CYC=2) covers reset, single word,
// fill/backpressure, push/pop concurrency and proto_err; instance B (SETUP_CYC=3) covers setup margin.
module tb_mt_sync_sender;
   localparam int DW    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mt_sync_sender_if #(.DATA_W(DW)) bus_a ();
   mt_sync_sender_if #(.DATA_W(DW)) bus_b ();

   logic [CW-1:0] cnt_a, cnt_b;
   logic          busy_a, busy_b, perr_a, perr_b;

   mt_sync_sender #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SETUP_CYC(2), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a),
      .fifo_count(cnt_a), .busy(busy_a), .proto_err(perr_a)
   );

   mt_sync_sender #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SETUP_CYC(3), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b),
      .fifo_count(cnt_b), .busy(busy_b), .proto_err(perr_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pipeline ack models: echo mt_req after a few clocks, acting at +2 so they never race the main flow.
   logic ack_en_a = 1'b0, ack_en_b = 1'b0;
   int   ack_cnt_a = 0, ack_cnt_b = 0;
   always @(posedge clk) begin
      #2;
      if (ack_en_a && reset_n && (bus_a.mt_req !== bus_a.mt_ack)) begin
         ack_cnt_a++;
         if (ack_cnt_a >= 3) begin
            bus_a.mt_ack = bus_a.mt_req;
            ack_cnt_a = 0;
         end
      end else ack_cnt_a = 0;
   end
   always @(posedge clk) begin
      #2;
      if (ack_en_b && reset_n && (bus_b.mt_req !== bus_b.mt_ack)) begin
         ack_cnt_b++;
         if (ack_cnt_b >= 2) begin
            bus_b.mt_ack = bus_b.mt_req;
            ack_cnt_b = 0;
         end
      end else ack_cnt_b = 0;
   end

   // Delivery monitor for A: one line per mt_req toggle, word captured into got_q.
   logic [DW-1:0] got_q[$];
   logic prev_req_a = 1'b0;
   always @(posedge clk) begin
      #1;
      if (!reset_n) prev_req_a = 1'b0;
      else if (bus_a.mt_req !== prev_req_a) begin
         prev_req_a = bus_a.mt_req;
         got_q.push_back(bus_a.mt_data);
         $display("A deliver word=%0h req=%0b", bus_a.mt_data, bus_a.mt_req);
      end
   end

   // Setup-margin monitor for B: mt_data must be stable for exactly 3 edges before each toggle.
   logic [DW-1:0] prev_data_b = '0;
   logic prev_req_b = 1'b0;
   int   stable_b = 0;
   int   toggles_b = 0;
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         prev_data_b = '0;
         prev_req_b = 1'b0;
         stable_b = 0;
      end else begin
         stable_b++;
         if (bus_b.mt_data !== prev_data_b) begin
            chk("b_load_in_phase", 32'(bus_b.mt_ack), 32'(bus_b.mt_req));
            stable_b = 0;
            prev_data_b = bus_b.mt_data;
         end
         if (bus_b.mt_req !== prev_req_b) begin
            chk("b_setup_edges", stable_b, 3);
            toggles_b++;
            prev_req_b = bus_b.mt_req;
            $display("B deliver word=%0h stable=%0d", bus_b.mt_data, stable_b);
         end
      end
   end

   task automatic wait_idle_a(input string tag, input int budget);
      int n = 0;
      while (busy_a && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(busy_a), 0);
   endtask

   // Wait for A's req toggle, answer it by hand, and stop just before the pop edge.
   task automatic ack_to_idle_a();
      int n = 0;
      while ((bus_a.mt_req === bus_a.mt_ack) && n < 20) begin
         tick();
         n++;
      end
      chk("a_req_pending", 32'(bus_a.mt_req ^ bus_a.mt_ack), 1);
      bus_a.mt_ack = bus_a.mt_req;
      repeat (3) tick();
   endtask

   initial begin
      bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.mt_ack = 1'b0;
      bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.mt_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_req", 32'(bus_a.mt_req), 0);
      chk("rst_data", 32'(bus_a.mt_data), 0);
      chk("rst_ready", 32'(bus_a.s_ready), 1);
      chk("rst_busy", 32'(busy_a), 0);

      // Single word with latency checks.
      ack_en_a = 1'b1;
      bus_a.s_valid = 1'b1; bus_a.s_data = 4'hA;
      tick();
      bus_a.s_valid = 1'b0;
      chk("p0_count", 32'(cnt_a), 1);
      chk("p0_data", 32'(bus_a.mt_data), 0);
      tick();
      chk("p1_data", 32'(bus_a.mt_data), 32'hA);
      chk("p1_req", 32'(bus_a.mt_req), 0);
      tick();
      chk("p2_req", 32'(bus_a.mt_req), 0);
      tick();
      chk("p3_req", 32'(bus_a.mt_req), 1);
      wait_idle_a("single_idle", 30);

      // Fill with ack withheld, then release and check order.
      ack_en_a = 1'b0;
      got_q.delete();
      for (int k = 1; k <= 5; k++) begin
         bus_a.s_valid = 1'b1; bus_a.s_data = DW'(k);
         tick();
      end
      chk("fill_count", 32'(cnt_a), 4);
      chk("fill_ready", 32'(bus_a.s_ready), 0);
      bus_a.s_data = 4'h6;
      tick();
      bus_a.s_valid = 1'b0;
      chk("full_push_ignored", 32'(cnt_a), 4);
      ack_en_a = 1'b1;
      wait_idle_a("fill_idle", 300);
      chk("fill_n_words", got_q.size(), 5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) chk("fill_order", 32'(got_q[i]), i + 1);

      // Setup margin on B, running alongside.
      ack_en_b = 1'b1;
      bus_b.s_valid = 1'b1;
      bus_b.s_data = 4'h3; tick();
      bus_b.s_data = 4'hC; tick();
      bus_b.s_data = 4'h5; tick();
      bus_b.s_valid = 1'b0;
      for (int n = 0; n < 200 && busy_b; n++) tick();
      chk("b_idle", 32'(busy_b), 0);
      chk("b_toggles", toggles_b, 3);

      // Concurrency: pop while full refuses push; pop with room keeps count.
      ack_en_a = 1'b0;
      for (int k = 9; k <= 13; k++) begin
         bus_a.s_valid = 1'b1; bus_a.s_data = DW'(k);
         tick();
      end
      bus_a.s_valid = 1'b0;
      chk("cc_full", 32'(cnt_a), 4);
      ack_to_idle_a();
      chk("cc_still_full", 32'(cnt_a), 4);
      bus_a.s_valid = 1'b1; bus_a.s_data = 4'hE;
      tick();
      bus_a.s_valid = 1'b0;
      chk("cc_full_pop", 32'(cnt_a), 3);
      chk("cc_full_pop_data", 32'(bus_a.mt_data), 32'hA);
      ack_to_idle_a();
      tick();
      chk("cc_pop_only", 32'(cnt_a), 2);
      ack_to_idle_a();
      bus_a.s_valid = 1'b1; bus_a.s_data = 4'hE;
      tick();
      bus_a.s_valid = 1'b0;
      chk("cc_push_pop", 32'(cnt_a), 2);
      chk("cc_push_pop_data", 32'(bus_a.mt_data), 32'hC);
      ack_en_a = 1'b1;
      wait_idle_a("cc_idle", 300);
      chk("cc_perr", 32'(perr_a), 0);

      // Protocol error: ack toggles while idle.
      ack_en_a = 1'b0;
      bus_a.mt_ack = ~bus_a.mt_ack;
      tick(); tick();
      chk("perr_early", 32'(perr_a), 0);
      tick();
      chk("perr_set", 32'(perr_a), 1);
      bus_a.s_valid = 1'b1; bus_a.s_data = 4'h5;
      tick();
      bus_a.s_valid = 1'b0;
      wait_idle_a("perr_xfer_idle", 50);
      chk("perr_xfer_data", 32'(bus_a.mt_data), 5);
      chk("perr_sticky", 32'(perr_a), 1);

      // Reset in the middle of WAIT_ACK.
      bus_a.s_valid = 1'b1; bus_a.s_data = 4'h6;
      tick();
      bus_a.s_valid = 1'b0;
      for (int n = 0; n < 20 && (bus_a.mt_req === bus_a.mt_ack); n++) tick();
      chk("pre_rst_data", 32'(bus_a.mt_data), 6);
      #2 reset_n = 1'b0;
      bus_a.mt_ack = 1'b0; bus_b.mt_ack = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus_a.mt_req), 0);
      chk("mid_rst_data", 32'(bus_a.mt_data), 0);
      chk("mid_rst_count", 32'(cnt_a), 0);
      chk("mid_rst_ready", 32'(bus_a.s_ready), 1);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_perr", 32'(perr_a), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
